hr_calc: RTL
============

HR_CALC -- requirements
Module: hr_calc

Interface
REQ-001 Parameter DATA_WIDTH, default 11: width of the RR period input, in samples.
REQ-002 Parameter FS, default 360: sampling rate in Hz; the dividend is DIVIDEND = 60*FS.
REQ-003 Parameter RR_MIN, default 72: shortest accepted RR period in samples (300 bpm at 360 Hz).
REQ-004 Parameter RR_MAX, default 1080: longest accepted RR period in samples (20 bpm at 360 Hz).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 ce  in  1  clock enable; when low, all state holds.
REQ-008 rr_period  in  DATA_WIDTH  RR interval from the R-peak detector, unsigned.
REQ-009 rr_period_updated  in  1  one-cycle strobe; rr_period is valid on this cycle.
REQ-010 hr_bpm  out  8  heart rate in bpm, floor division, saturated at 255.
REQ-011 hr_valid  out  1  one-cycle pulse when hr_bpm is updated.
REQ-012 rr_avg  out  DATA_WIDTH  RR value used as the divisor for the latest hr_bpm.
REQ-013 rr_out_of_range  out  1  one-cycle pulse when a captured rr_period is outside [RR_MIN, RR_MAX].
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 overrun  out  1  sticky; set when a strobe is dropped while busy; cleared only by reset.

Function
REQ-016 FSM states: IDLE, CHECK, ACCUM, DIV, DONE; all transitions require ce=1.
REQ-017 IDLE: when rr_period_updated=1, the block captures rr_period and goes to CHECK.
REQ-018 CHECK: if the captured value is below RR_MIN or above RR_MAX, the block pulses rr_out_of_range and returns to IDLE; history, rr_avg and hr_bpm are unchanged; otherwise the block goes to ACCUM.
REQ-019 ACCUM: the block computes the divisor (see REQ-028/029), loads it into rr_avg, and goes to DIV.
REQ-020 DIV: a restoring divider produces one quotient bit per cycle; quotient width QW = $clog2(DIVIDEND+1) (15 for defaults); DIV lasts exactly QW cycles, then the block goes to DONE.
REQ-021 DONE: the block loads hr_bpm = min(quotient, 255), pulses hr_valid for one cycle, and returns to IDLE.
REQ-022 Latency: hr_valid is high exactly QW+3 ce-enabled cycles after the capture edge (18 for defaults).
REQ-023 A strobe arriving in any non-IDLE state is dropped and sets overrun; the in-flight computation is unaffected.
REQ-024 A strobe in the same cycle as DONE is dropped (busy=1), and overrun is set.
REQ-025 ce=0 freezes the FSM, divider and history; hr_valid and rr_out_of_range are 0 while ce=0; a strobe with ce=0 is ignored and does not set overrun.
REQ-026 The divider remainder is at least DATA_WIDTH+1 bits wide; the divisor is never 0, guaranteed by RR_MIN>0.

Reset
REQ-027 On rst=1, the block asynchronously enters IDLE and clears hr_bpm, hr_valid, rr_avg, rr_out_of_range, busy, overrun, the divider registers, and the history (all entries, sum, fill count); asserting rst mid-DIV aborts the computation with no hr_valid pulse.

Configuration
REQ-028 With HR_AVG_EN defined: an 8-entry circular buffer holds accepted RR values; ACCUM writes the new value, updates the running sum (DATA_WIDTH+3 bits) as sum + new - oldest, and sets the divisor to sum>>3 once 8 entries have been accepted; before that, the divisor is the raw captured value.
REQ-029 With HR_AVG_EN undefined: no buffer or sum is built, and the divisor is the raw captured rr_period.

Verification
REQ-030 rr_period=360 strobe -> hr_valid 18 cycles later, hr_bpm=60, rr_avg=360; rr_period=288 -> hr_bpm=75.
REQ-031 rr_period=72 -> hr_bpm=255 (saturated from 300); rr_period=71 and rr_period=1081 -> rr_out_of_range pulse, no hr_valid, hr_bpm held.
REQ-032 Strobe at rr=360, then a second strobe 5 cycles later -> a single hr_valid with hr_bpm=60, and overrun=1.
REQ-033 rst asserted during DIV -> immediate IDLE, all outputs 0, no hr_valid; the next strobe rr=100 -> hr_bpm=216.
REQ-034 HR_AVG_EN defined: 8 strobes rr=360 then one strobe rr=180 -> rr_avg=337, hr_bpm=64; the first strobe after reset with rr=180 -> hr_bpm=120.
REQ-035 ce toggled 1-0-1 every cycle during a computation -> hr_valid arrives after 18 ce-high cycles with an unchanged result.

Source files
------------

// File: rtl/hr_calc.sv
// hr_calc: converts an RR interval (in samples) into a heart rate in bpm
// using a bit-serial restoring divider: hr_bpm = min(60*FS / divisor, 255).
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   ce                 clock enable; all state holds while low
//   rr_period          RR interval from the R-peak detector (unsigned)
//   rr_period_updated  one-cycle strobe qualifying rr_period
//   hr_bpm             latest heart rate, saturated at 255
//   hr_valid           one-cycle pulse when hr_bpm updates
//   rr_avg             divisor used for the latest hr_bpm
//   rr_out_of_range    one-cycle pulse when a captured RR is rejected
//   busy               high whenever a capture is being processed
//   overrun            sticky flag: a strobe was dropped while busy
//
// Build option: define HR_AVG_EN to divide by the mean of the last eight
// accepted RR values (raw value is used until eight have been accepted).
module hr_calc #(
   parameter int DATA_WIDTH = 11,
   parameter int FS         = 360,
   parameter int RR_MIN     = 72,
   parameter int RR_MAX     = 1080
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [DATA_WIDTH-1:0] rr_period,
   input  logic                  rr_period_updated,
   output logic [7:0]            hr_bpm,
   output logic                  hr_valid,
   output logic [DATA_WIDTH-1:0] rr_avg,
   output logic                  rr_out_of_range,
   output logic                  busy,
   output logic                  overrun
);

   localparam int DIVIDEND = 60 * FS;
   localparam int QW       = $clog2(DIVIDEND + 1);
   localparam int RW       = DATA_WIDTH + 1;
   localparam int CW       = $clog2(QW + 1);

   localparam logic [QW-1:0]         DVD    = QW'(DIVIDEND);
   localparam logic [QW-1:0]         SAT    = QW'(255);
   localparam logic [CW-1:0]         LAST   = CW'(QW - 1);
   localparam logic [DATA_WIDTH-1:0] MIN_RR = DATA_WIDTH'(RR_MIN);
   localparam logic [DATA_WIDTH-1:0] MAX_RR = DATA_WIDTH'(RR_MAX);

   typedef enum logic [2:0] {IDLE, CHECK, ACCUM, DIV, DONE} state_t;

   state_t                  state, state_next;
   logic [DATA_WIDTH-1:0]   cap;
   logic [DATA_WIDTH-1:0]   divisor;
   logic [QW-1:0]           dvd;
   logic [QW-1:0]           quo;
   logic [RW-1:0]           rem;
   logic [RW-1:0]           rem_sh;
   logic [RW-1:0]           rem_nx;
   logic                    q_bit;
   logic [CW-1:0]           cnt;
   logic                    valid_q;
   logic                    oor_q;
   logic                    out_range;

   assign out_range = (cap < MIN_RR) || (cap > MAX_RR);

   // One restoring-division step: bring in the next dividend bit, subtract
   // the divisor if it fits.
   always_comb begin
      rem_sh = RW'({rem, dvd[QW-1]});
      q_bit  = (rem_sh >= {1'b0, rr_avg});
      rem_nx = q_bit ? (rem_sh - {1'b0, rr_avg}) : rem_sh;
   end

`ifdef HR_AVG_EN
   logic [DATA_WIDTH-1:0] hist [8];
   logic [2:0]            wr_ptr;
   logic [3:0]            fill;
   logic [DATA_WIDTH+2:0] sum;
   logic [DATA_WIDTH+2:0] sum_nx;

   // Unwritten slots read as zero, so the same update works while filling.
   always_comb begin
      sum_nx  = sum + {3'b000, cap} - {3'b000, hist[wr_ptr]};
      divisor = (fill >= 4'd7) ? DATA_WIDTH'(sum_nx >> 3) : cap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 8; i++) hist[i] <= '0;
         wr_ptr <= '0;
         fill   <= '0;
         sum    <= '0;
      end else if (ce && state == ACCUM) begin
         hist[wr_ptr] <= cap;
         wr_ptr       <= wr_ptr + 3'd1;
         sum          <= sum_nx;
         if (fill != 4'd8) fill <= fill + 4'd1;
      end
   end
`else
   always_comb divisor = cap;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      if (ce) begin
         case (state)
            IDLE:    if (rr_period_updated) state_next = CHECK;
            CHECK:   state_next = out_range ? IDLE : ACCUM;
            ACCUM:   state_next = DIV;
            DIV:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap     <= '0;
         rr_avg  <= '0;
         dvd     <= '0;
         quo     <= '0;
         rem     <= '0;
         cnt     <= '0;
         hr_bpm  <= '0;
         valid_q <= 1'b0;
         oor_q   <= 1'b0;
         overrun <= 1'b0;
      end else if (ce) begin
         valid_q <= (state == DONE);
         oor_q   <= (state == CHECK) && out_range;
         if (rr_period_updated && state != IDLE) overrun <= 1'b1;
         case (state)
            IDLE:  if (rr_period_updated) cap <= rr_period;
            ACCUM: begin
               rr_avg <= divisor;
               dvd    <= DVD;
               quo    <= '0;
               rem    <= '0;
               cnt    <= '0;
            end
            DIV: begin
               rem <= rem_nx;
               dvd <= dvd << 1;
               quo <= {quo[QW-2:0], q_bit};
               cnt <= cnt + 1'b1;
            end
            DONE:  hr_bpm <= (quo > SAT) ? 8'hFF : quo[7:0];
            default: ;
         endcase
      end
   end

   // Pulses are held across ce-low cycles and shown on the next enabled one.
   assign hr_valid        = valid_q & ce;
   assign rr_out_of_range = oor_q & ce;

endmodule
